matrix_alu: RTL and testbench



---
 rtl/matrix_pkg.sv | 34 +++
 rtl/matrix_alu_elem_sat.sv | 36 +++
 rtl/matrix_alu.sv | 194 +++++++++++++++++++
 tb/tb_matrix_alu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix ALU and the HPS buffer.
//   ROWS, COLS, ELEMENT_BITS, MATRIX_BITS : matrix geometry
//   ACC_BITS                              : full-width element/accumulator width
//   op_t                                  : opcode encoding (instruction[2:0])
//   alu_state_t                           : ALU sequencing states
package matrix_pkg;

    localparam int ROWS         = 5;
    localparam int COLS         = 5;
    localparam int ELEMENT_BITS = 8;
    localparam int MATRIX_BITS  = ROWS * COLS * ELEMENT_BITS;
    localparam int ACC_BITS     = 20;

    typedef enum logic [2:0] {
        OP_ADD       = 3'd0,
        OP_SUB       = 3'd1,
        OP_MUL       = 3'd2,
        OP_SCALAR    = 3'd3,
        OP_TRANSPOSE = 3'd4,
        OP_OPPOSITE  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } alu_state_t;

    // Opcodes 6 and 7 are undefined.
    function automatic logic op_is_valid(input logic [2:0] opc);
        return opc <= 3'd5;
    endfunction

endpackage

// File: rtl/matrix_alu_elem_sat.sv
// matrix_elem_sat: reduces a full-width signed element to ELEMENT_BITS.
// Build switch: MATRIX_ALU_SATURATE_EN defined -> clamp to the signed range,
// otherwise keep the low bits (wrap). overflow is the same in both builds.
//   value    in  IN_BITS   signed full-width element
//   elem     out OUT_BITS  reduced element
//   overflow out 1         value lies outside the OUT_BITS signed range
module matrix_elem_sat
    import matrix_pkg::*;
#(
    parameter int IN_BITS  = ACC_BITS,
    parameter int OUT_BITS = ELEMENT_BITS
) (
    input  logic signed [IN_BITS-1:0]  value,
    output logic        [OUT_BITS-1:0] elem,
    output logic                       overflow
);

    localparam logic signed [IN_BITS-1:0] MAX_V = IN_BITS'((2 ** (OUT_BITS - 1)) - 1);
    localparam logic signed [IN_BITS-1:0] MIN_V = IN_BITS'(-(2 ** (OUT_BITS - 1)));

    always_comb begin
        overflow = (value > MAX_V) || (value < MIN_V);
`ifdef MATRIX_ALU_SATURATE_EN
        if (value > MAX_V) begin
            elem = MAX_V[OUT_BITS-1:0];
        end else if (value < MIN_V) begin
            elem = MIN_V[OUT_BITS-1:0];
        end else begin
            elem = value[OUT_BITS-1:0];
        end
`else
        elem = value[OUT_BITS-1:0];
`endif
    end

endmodule

// File: rtl/matrix_alu.sv
// matrix_alu: sequential arithmetic engine for two ROWS x COLS signed matrices.
// One result element per cycle (one MAC per cycle for MUL). Optional build
// macro MATRIX_ALU_SATURATE_EN (in matrix_elem_sat) clamps instead of wrapping.
//   clk         in  1            clock, rising edge
//   rst         in  1            synchronous active-high reset
//   start       in  1            request operation, sampled only in IDLE
//   matrix_a    in  MATRIX_BITS  operand A, element (r,c) MSB-first row-major
//   matrix_b    in  MATRIX_BITS  operand B
//   instruction in  6            [2:0] opcode, [5:3] ignored
//   busy        out 1            high in COMPUTE
//   done        out 1            one-cycle pulse in DONE
//   result      out MATRIX_BITS  result, final from done until next start
//   overflow    out 1            sticky per operation
//   invalid_op  out 1            opcode 6 or 7
//
// state   | meaning
// IDLE    | waiting for start; result held
// COMPUTE | writing one element (or one MAC) per cycle
// DONE    | single-cycle completion pulse
module matrix_alu
    import matrix_pkg::*;
#(
    parameter int ROWS         = matrix_pkg::ROWS,
    parameter int COLS         = matrix_pkg::COLS,
    parameter int ELEMENT_BITS = matrix_pkg::ELEMENT_BITS,
    localparam int MATRIX_BITS = ROWS * COLS * ELEMENT_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MATRIX_BITS-1:0] matrix_a,
    input  logic [MATRIX_BITS-1:0] matrix_b,
    input  logic [5:0]             instruction,
    output logic                   busy,
    output logic                   done,
    output logic [MATRIX_BITS-1:0] result,
    output logic                   overflow,
    output logic                   invalid_op
);

    localparam int N_ELEM = ROWS * COLS;
    localparam int EW     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IW     = $clog2(MATRIX_BITS);

    // Top bit position of element idx in a packed matrix.
    function automatic logic [IW-1:0] elem_hi(input int idx);
        return IW'(MATRIX_BITS - 1 - ELEMENT_BITS * idx);
    endfunction

    function automatic logic signed [ELEMENT_BITS-1:0] pick(input logic [MATRIX_BITS-1:0] m,
                                                            input int idx);
        return $signed(m[elem_hi(idx) -: ELEMENT_BITS]);
    endfunction

    alu_state_t state_q, state_d;

    logic [MATRIX_BITS-1:0]      a_q, b_q, result_q;
    op_t                         op_q;
    logic [EW-1:0]               e_q;
    logic [RW-1:0]               r_q;
    logic [CW-1:0]               c_q;
    logic [CW-1:0]               k_q;
    logic signed [ACC_BITS-1:0]  acc_q;
    logic                        overflow_q, invalid_q;

    int                          idx_rc, idx_cr, idx_rk, idx_kc;
    logic signed [ACC_BITS-1:0]  ax, bx, atx, b00x, prod, mac, val;
    logic [ELEMENT_BITS-1:0]     sat_elem;
    logic                        sat_ovf;
    logic                        mac_last, wr_en, last_elem, accept;
    logic                        unused_reserved;

    assign unused_reserved = ^instruction[5:3];

    // Operand fetch and full-width element value.
    always_comb begin
        idx_rc = int'(r_q) * COLS + int'(c_q);
        idx_cr = int'(c_q) * COLS + int'(r_q);
        idx_rk = int'(r_q) * COLS + int'(k_q);
        idx_kc = int'(k_q) * COLS + int'(c_q);

        ax   = ACC_BITS'(pick(a_q, idx_rc));
        bx   = ACC_BITS'(pick(b_q, idx_rc));
        atx  = ACC_BITS'(pick(a_q, idx_cr));
        b00x = ACC_BITS'(pick(b_q, 0));
        prod = ACC_BITS'(pick(a_q, idx_rk)) * ACC_BITS'(pick(b_q, idx_kc));
        mac  = acc_q + prod;

        val = '0;
        case (op_q)
            OP_ADD:       val = ax + bx;
            OP_SUB:       val = ax - bx;
            OP_MUL:       val = mac;
            OP_SCALAR:    val = ax * b00x;
            OP_TRANSPOSE: val = atx;
            OP_OPPOSITE:  val = -ax;
            default:      val = '0;
        endcase
    end

    matrix_elem_sat #(
        .IN_BITS  (ACC_BITS),
        .OUT_BITS (ELEMENT_BITS)
    ) u_sat (
        .value    (val),
        .elem     (sat_elem),
        .overflow (sat_ovf)
    );

    // MUL writes only on the last product term of each element.
    assign mac_last  = (k_q == CW'(COLS - 1));
    assign wr_en     = (state_q == COMPUTE) && ((op_q != OP_MUL) || mac_last);
    assign last_elem = wr_en && (e_q == EW'(N_ELEM - 1));
    assign accept    = (state_q == IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = op_is_valid(instruction[2:0]) ? COMPUTE : DONE;
            COMPUTE: if (last_elem) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state_q == COMPUTE);
        done = (state_q == DONE);
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            result_q   <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
            e_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
        end else if (accept) begin
            a_q        <= matrix_a;
            b_q        <= matrix_b;
            op_q       <= op_t'(instruction[2:0]);
            result_q   <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= ~op_is_valid(instruction[2:0]);
            e_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
        end else if (state_q == COMPUTE) begin
            if (wr_en) begin
                result_q[elem_hi(idx_rc) -: ELEMENT_BITS] <= sat_elem;
                overflow_q <= overflow_q | sat_ovf;
                acc_q      <= '0;
                k_q        <= '0;
                e_q        <= e_q + 1'b1;
                if (c_q == CW'(COLS - 1)) begin
                    c_q <= '0;
                    r_q <= r_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end else begin
                acc_q <= mac;
                k_q   <= k_q + 1'b1;
            end
        end
    end

    assign result     = result_q;
    assign overflow   = overflow_q;
    assign invalid_op = invalid_q;

endmodule

// File: tb/tb_matrix_alu.sv
module tb_matrix_alu;
    import matrix_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [MATRIX_BITS-1:0] matrix_a, matrix_b;
    logic [5:0]             instruction;
    logic                   busy, done, overflow, invalid_op;
    logic [MATRIX_BITS-1:0] result;

    always #5 clk = ~clk;

    matrix_alu dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .matrix_a    (matrix_a),
        .matrix_b    (matrix_b),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .invalid_op  (invalid_op)
    );

    typedef struct {
        logic [MATRIX_BITS-1:0] res;
        logic                   ovf;
        logic                   inv;
        int                     lat;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string tag, input logic [MATRIX_BITS-1:0] obs,
                         input logic [MATRIX_BITS-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int gel(input logic [MATRIX_BITS-1:0] m, input int r, input int c);
        logic signed [7:0] t;
        t = m[MATRIX_BITS-1-8*(r*5+c) -: 8];
        return int'(t);
    endfunction

    function automatic logic [MATRIX_BITS-1:0] put(input logic [MATRIX_BITS-1:0] m,
                                                   input int r, input int c, input int v);
        logic [MATRIX_BITS-1:0] x;
        x = m;
        x[MATRIX_BITS-1-8*(r*5+c) -: 8] = v[7:0];
        return x;
    endfunction

    function automatic logic [MATRIX_BITS-1:0] fill(input int v);
        logic [MATRIX_BITS-1:0] x = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) x = put(x, r, c, v);
        return x;
    endfunction

    function automatic logic [MATRIX_BITS-1:0] ramp(input int scale, input int ofs);
        logic [MATRIX_BITS-1:0] x = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) x = put(x, r, c, (r*5+c)*scale + ofs);
        return x;
    endfunction

    function automatic logic [MATRIX_BITS-1:0] ident();
        logic [MATRIX_BITS-1:0] x = '0;
        for (int i = 0; i < 5; i++) x = put(x, i, i, 1);
        return x;
    endfunction

    // Reference model working in plain integers.
    function automatic exp_t model(input logic [MATRIX_BITS-1:0] a, input logic [MATRIX_BITS-1:0] b,
                                   input logic [5:0] ins);
        exp_t x;
        int   v;
        int   op;
        op    = int'(ins[2:0]);
        x.res = '0;
        x.ovf = 1'b0;
        x.inv = (op > 5);
        x.lat = (op > 5) ? 0 : (op == 2) ? 125 : 25;
        if (!x.inv) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    case (op)
                        0: v = gel(a, r, c) + gel(b, r, c);
                        1: v = gel(a, r, c) - gel(b, r, c);
                        2: begin
                            v = 0;
                            for (int k = 0; k < 5; k++) v += gel(a, r, k) * gel(b, k, c);
                        end
                        3: v = gel(a, r, c) * gel(b, 0, 0);
                        4: v = gel(a, c, r);
                        default: v = -gel(a, r, c);
                    endcase
                    if (v > 127 || v < -128) begin
                        x.ovf = 1'b1;
`ifdef MATRIX_ALU_SATURATE_EN
                        v = (v > 127) ? 127 : -128;
`endif
                    end
                    x.res = put(x.res, r, c, v);
                end
            end
        end
        return x;
    endfunction

    // Drive start for exactly one edge (edge N); return at N + 1 time unit.
    task automatic issue(input logic [MATRIX_BITS-1:0] a, input logic [MATRIX_BITS-1:0] b,
                         input logic [5:0] ins);
        sb.push_back(model(a, b, ins));
        @(negedge clk);
        matrix_a    = a;
        matrix_b    = b;
        instruction = ins;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done (bounded), pop and compare. poke > 0 pulses start and
    // scrambles operands that many cycles into COMPUTE.
    task automatic finish_op(input string tag, input int poke);
        exp_t x;
        int   lat;
        logic prev_busy;
        lat       = -1;
        prev_busy = 1'b0;
        for (int i = 0; i <= 300; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (poke > 0 && i == poke) begin
                start       = 1'b1;
                instruction = 6'd0;
                matrix_a    = ~matrix_a;
                matrix_b    = ~matrix_b;
            end else begin
                start = 1'b0;
            end
            prev_busy = busy;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        x = sb.pop_front();
        check({tag, " latency"}, MATRIX_BITS'(lat), MATRIX_BITS'(x.lat));
        check({tag, " result"}, result, x.res);
        check({tag, " overflow"}, MATRIX_BITS'(overflow), MATRIX_BITS'(x.ovf));
        check({tag, " invalid_op"}, MATRIX_BITS'(invalid_op), MATRIX_BITS'(x.inv));
        check({tag, " busy at done"}, MATRIX_BITS'(busy), '0);
        if (x.lat > 0)
            check({tag, " busy before done"}, MATRIX_BITS'(prev_busy), MATRIX_BITS'(1));
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, MATRIX_BITS'(done), '0);
        check({tag, " busy after"}, MATRIX_BITS'(busy), '0);
        check({tag, " result held"}, result, x.res);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        matrix_a    = '0;
        matrix_b    = '0;
        instruction = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", MATRIX_BITS'(busy), '0);
        check("reset done", MATRIX_BITS'(done), '0);
        check("reset result", result, '0);
        check("reset overflow", MATRIX_BITS'(overflow), '0);
        check("reset invalid_op", MATRIX_BITS'(invalid_op), '0);
        rst = 1'b0;

        issue(fill(1), fill(2), 6'd0);
        check("add expected all 3", sb[0].res, fill(3));
        finish_op("add", 0);

        issue(ident(), ramp(1, 0), 6'd2);
        check("mul expected equals B", sb[0].res, ramp(1, 0));
        finish_op("mul identity", 0);

        issue(fill(-128), fill(1), 6'd1);
        finish_op("sub overflow", 0);

        issue(ramp(1, 0), fill(9), 6'd4);
        finish_op("transpose with ignored start", 5);

        issue(fill(5), fill(5), 6'b101_111);
        finish_op("invalid opcode", 0);

        issue(fill(3), put(fill(0), 0, 0, -2), 6'b110_011);
        check("scalar expected all -6", sb[0].res, fill(-6));
        finish_op("scalar", 0);

        issue(ramp(10, -128), fill(0), 6'd5);
        finish_op("opposite", 0);

        issue(fill(10), fill(10), 6'd2);
        finish_op("mul overflow", 0);

        // Reset at edge N+60 of a MUL.
        @(negedge clk);
        matrix_a    = fill(7);
        matrix_b    = fill(3);
        instruction = 6'd2;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (59) @(posedge clk);
        #1;
        check("mid-mul busy", MATRIX_BITS'(busy), MATRIX_BITS'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid reset busy", MATRIX_BITS'(busy), '0);
        check("mid reset done", MATRIX_BITS'(done), '0);
        check("mid reset result", result, '0);
        check("mid reset overflow", MATRIX_BITS'(overflow), '0);
        check("mid reset invalid_op", MATRIX_BITS'(invalid_op), '0);

        issue(fill(100), fill(50), 6'd0);
        finish_op("add after reset", 0);

        issue(ramp(1, 0), ramp(1, 0), 6'd2);
        finish_op("mul after reset", 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
